// File: rtl/seg_led_driver.sv
// seg_led_driver
//   Output stage for the board display: 8-digit multiplexed seven-segment
//   display, 24-bit LED bank and a blink LED.  The 24-bit display value is
//   shown either as hex or as decimal (sequential double dabble, leading
//   zeros blanked).  Digit registers are only rewritten as a complete set,
//   so a half-converted value is never visible.
//
// Ports
//   clock         system clock
//   reset         synchronous reset, active-high
//   data_display  24-bit value to show
//   dec_mode      1 = decimal, 0 = hex
//   led_display   LED pattern
//   blink_need    blink request
//   seg_out       segments, active-low, {dp,g,f,e,d,c,b,a}
//   seg_en        digit enables, active-low, bit 0 = rightmost digit
//   led_out       registered LED pattern
//   blink_out     blinking LED
//   conv_busy     decimal conversion in progress
//
// Conversion FSM
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | compare inputs with latched copy, capture on difference
//   HEX       | load digits 0..5 from latched nibbles, 6..7 blank
//   DEC_SHIFT | one double-dabble iteration per cycle, 24 in total
//   DONE      | load all 8 digits from BCD result with leading-zero blanking

module seg_led_driver #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000,
    parameter int BLINK_HZ = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [23:0] data_display,
    input  logic        dec_mode,
    input  logic [23:0] led_display,
    input  logic        blink_need,
    output logic [7:0]  seg_out,
    output logic [7:0]  seg_en,
    output logic [23:0] led_out,
    output logic        blink_out,
    output logic        conv_busy
);

    localparam int TICK   = CLK_FREQ / (8 * SCAN_HZ);
    localparam int HALF   = CLK_FREQ / (2 * BLINK_HZ);
    localparam int TICK_W = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);

    // Digit register format: {blank, nibble}
    localparam logic [4:0] DIGIT_BLANK = 5'h10;

    typedef enum logic [1:0] {
        IDLE,
        HEX,
        DEC_SHIFT,
        DONE
    } conv_state_t;

    conv_state_t state, state_nxt;

    logic [TICK_W-1:0] tick_cnt;
    logic [2:0]        digit_idx;
    logic [4:0]        digit_q   [8];
    logic [4:0]        dec_digit [8];

    logic [24:0] latched_q;
    logic        valid_q;
    logic [23:0] bin_q;
    logic [31:0] bcd_q;
    logic [31:0] bcd_adj;
    logic [4:0]  iter_q;

    logic capture;
    logic shift_en;
    logic load_hex;
    logic load_dec;

    logic [HALF_W-1:0] blink_cnt;

    function automatic logic [7:0] seg_code(input logic [4:0] d);
        logic [7:0] c;
        if (d[4]) begin
            c = 8'hFF;
        end else begin
            case (d[3:0])
                4'h0:    c = 8'hC0;
                4'h1:    c = 8'hF9;
                4'h2:    c = 8'hA4;
                4'h3:    c = 8'hB0;
                4'h4:    c = 8'h99;
                4'h5:    c = 8'h92;
                4'h6:    c = 8'h82;
                4'h7:    c = 8'hF8;
                4'h8:    c = 8'h80;
                4'h9:    c = 8'h90;
                4'hA:    c = 8'h88;
                4'hB:    c = 8'h83;
                4'hC:    c = 8'hC6;
                4'hD:    c = 8'hA1;
                4'hE:    c = 8'h86;
                default: c = 8'h8E;
            endcase
        end
        return c;
    endfunction

    // ------------------------------------------------------------------
    // Scan: per-digit down-counter, digit index advances on terminal count
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt  <= TICK_LAST;
            digit_idx <= 3'd0;
        end else if (tick_cnt == '0) begin
            tick_cnt  <= TICK_LAST;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            tick_cnt  <= tick_cnt - TICK_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            seg_en  <= 8'hFF;
            seg_out <= 8'hFF;
        end else begin
            seg_en  <= ~(8'd1 << digit_idx);
            seg_out <= seg_code(digit_q[digit_idx]);
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        shift_en  = 1'b0;
        load_hex  = 1'b0;
        load_dec  = 1'b0;
        conv_busy = 1'b0;
        case (state)
            IDLE: begin
                if (!valid_q || ({dec_mode, data_display} != latched_q)) begin
                    capture   = 1'b1;
                    state_nxt = dec_mode ? DEC_SHIFT : HEX;
                end
            end
            HEX: begin
                load_hex  = 1'b1;
                state_nxt = IDLE;
            end
            DEC_SHIFT: begin
                conv_busy = 1'b1;
                shift_en  = 1'b1;
                if (iter_q == 5'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                load_dec  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 8; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking: a digit is shown only if it or a higher digit
    // is nonzero; digit 0 is always shown so that zero reads as "0".
    always_comb begin
        logic seen;
        seen = 1'b0;
        for (int i = 7; i >= 1; i--) begin
            seen         = seen | (bcd_q[4*i +: 4] != 4'd0);
            dec_digit[i] = seen ? {1'b0, bcd_q[4*i +: 4]} : DIGIT_BLANK;
        end
        dec_digit[0] = {1'b0, bcd_q[3:0]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            latched_q <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            iter_q    <= '0;
            for (int i = 0; i < 8; i++) begin
                digit_q[i] <= DIGIT_BLANK;
            end
        end else begin
            if (capture) begin
                valid_q   <= 1'b1;
                latched_q <= {dec_mode, data_display};
                bin_q     <= data_display;
                bcd_q     <= '0;
                iter_q    <= 5'd23;
            end
            if (shift_en) begin
                bcd_q  <= {bcd_adj[30:0], bin_q[23]};
                bin_q  <= {bin_q[22:0], 1'b0};
                iter_q <= iter_q - 5'd1;
            end
            if (load_hex) begin
                for (int i = 0; i < 6; i++) begin
                    digit_q[i] <= {1'b0, latched_q[4*i +: 4]};
                end
                digit_q[6] <= DIGIT_BLANK;
                digit_q[7] <= DIGIT_BLANK;
            end
            if (load_dec) begin
                for (int i = 0; i < 8; i++) begin
                    digit_q[i] <= dec_digit[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // LED bank and blink
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            led_out <= '0;
        end else begin
            led_out <= led_display;
        end
    end

    // blink_out is the blink phase itself; the half-period timer is held at
    // its reload value while no blink is requested, so the first toggle comes
    // HALF cycles after blink_need rises.
    always_ff @(posedge clock) begin
        if (reset || !blink_need) begin
            blink_cnt <= HALF_LAST;
            blink_out <= 1'b0;
        end else if (blink_cnt == '0) begin
            blink_cnt <= HALF_LAST;
            blink_out <= ~blink_out;
        end else begin
            blink_cnt <= blink_cnt - HALF_W'(1);
        end
    end

endmodule
